vr_hold_source: RTL and testbench

//  Upstream producer for the valid/ready link whose rule is: valid rises, holds with data until

---
 rtl/vr_pkg.sv | 15 +
 rtl/vr_hold_source_if.sv | 11 +
 rtl/vr_sync_fifo.sv | 54 +++++
 rtl/vr_hold_source.sv | 93 +++++++++
 tb/tb_vr_hold_source.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/vr_pkg.sv
// Shared types for the valid/ready hold link: producer FSM states and a width helper.
package vr_pkg;

    typedef enum logic [1:0] {
        VR_IDLE    = 2'd0,
        VR_PRESENT = 2'd1,
        VR_GAP     = 2'd2
    } vr_state_e;

    // Occupancy counters need one extra bit so "full" is representable.
    function automatic int vr_cw(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/vr_hold_source_if.sv
// Valid/ready link: valid rises and holds with data until a one-cycle ready, then both drop.
interface vr_hold_source_if #(
    parameter int DW = 8
) ();
    logic          valid;
    logic [DW-1:0] data;
    logic          ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/vr_sync_fifo.sv
// Small synchronous FIFO with head-of-queue read data and occupancy count.
module vr_sync_fifo
    import vr_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr,
    input  logic [DW-1:0]           wr_data,
    input  logic                    rd,
    output logic [DW-1:0]           rd_data,
    output logic [vr_cw(DEPTH)-1:0] count,
    output logic                    full,
    output logic                    empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = vr_cw(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_wr;
    logic          do_rd;

    // Full is judged before any same-cycle pop, so a write while full is always dropped.
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr && !full;
    assign do_rd   = rd && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vr_hold_source.sv
// Producer for the hold-until-ready link: buffers local writes and presents them one per
// PRESENT/GAP pair, flagging consumer protocol faults, stalls and writer overflow.
module vr_hold_source
    import vr_pkg::*;
#(
    parameter int DW      = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_wr,
    input  logic [DW-1:0]           in_data,
    output logic                    in_full,
    vr_hold_source_if.master        link,
    output logic [vr_cw(DEPTH)-1:0] count,
    output logic                    timeout_err,
    output logic                    proto_err,
    output logic                    ovf_err,
    output vr_state_e               state
);
    localparam int TW = $clog2(TIMEOUT + 1);

    vr_state_e     state_q;
    vr_state_e     state_d;
    logic [DW-1:0] head;
    logic          empty;
    logic          pop;
    logic [TW-1:0] tcnt;

    vr_sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr      (in_wr),
        .wr_data (in_data),
        .rd      (pop),
        .rd_data (head),
        .count   (count),
        .full    (in_full),
        .empty   (empty)
    );

    assign state = state_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= VR_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            VR_IDLE:    if (!empty) state_d = VR_PRESENT;
            VR_PRESENT: if (link.ready) state_d = VR_GAP;
            VR_GAP:     state_d = empty ? VR_IDLE : VR_PRESENT;
            default:    state_d = VR_IDLE;
        endcase
    end

    // The head is stable for the whole PRESENT interval because only an accept pops it.
    always_comb begin
        link.valid = (state_q == VR_PRESENT);
        link.data  = '0;
        pop        = 1'b0;
        if (state_q == VR_PRESENT) begin
            link.data = head;
            pop       = link.ready;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt        <= '0;
            timeout_err <= 1'b0;
            proto_err   <= 1'b0;
            ovf_err     <= 1'b0;
        end else begin
            if (state_q != VR_PRESENT && state_d == VR_PRESENT) begin
                tcnt <= '0;
            end else if (state_q == VR_PRESENT && !link.ready && tcnt != TW'(TIMEOUT)) begin
                tcnt <= tcnt + 1'b1;
            end
            // Flag on the cycle that completes TIMEOUT waiting cycles; valid keeps holding.
            if (state_q == VR_PRESENT && !link.ready && tcnt == TW'(TIMEOUT - 1))
                timeout_err <= 1'b1;
            if (link.ready && state_q != VR_PRESENT)
                proto_err <= 1'b1;
            if (in_wr && in_full)
                ovf_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vr_hold_source.sv
// Randomized and directed bench for vr_hold_source against a queue-based link model.
module tb_vr_hold_source;
  import vr_pkg::*;

  localparam int DW      = 8;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;
  localparam int CW      = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_wr = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_full;
  logic [CW-1:0] count;
  logic          timeout_err;
  logic          proto_err;
  logic          ovf_err;
  vr_state_e     state;

  vr_hold_source_if #(.DW(DW)) link ();

  vr_hold_source #(.DW(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_wr       (in_wr),
    .in_data     (in_data),
    .in_full     (in_full),
    .link        (link),
    .count       (count),
    .timeout_err (timeout_err),
    .proto_err   (proto_err),
    .ovf_err     (ovf_err),
    .state       (state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / model ----------------
  int n_total = 0;
  int n_bad   = 0;

  logic [DW-1:0] exp_q[$];
  bit m_pres;
  int m_wait;
  bit m_to;
  bit m_pe;
  bit m_ovf;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge of the link rules: a presented word holds until ready, then one silent
  // cycle; otherwise a word is presented whenever the buffer was non-empty.
  task automatic model_edge(input bit r, input bit wr, input logic [DW-1:0] d, input bit rdy);
    int  sz;
    bit  nxt;
    if (r) begin
      exp_q.delete();
      m_pres = 0; m_wait = 0; m_to = 0; m_pe = 0; m_ovf = 0;
      return;
    end
    sz = exp_q.size();
    if (rdy && !m_pres) m_pe = 1;
    if (wr && sz == DEPTH) m_ovf = 1;
    else if (wr) exp_q.push_back(d);
    if (m_pres && !rdy) begin
      m_wait++;
      if (m_wait >= TIMEOUT) m_to = 1;
    end
    if (m_pres && rdy) void'(exp_q.pop_front());
    nxt = m_pres ? !rdy : (sz != 0);
    if (!m_pres && nxt) m_wait = 0;
    m_pres = nxt;
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ":valid"}, 32'(link.valid), 32'(m_pres));
    check_eq({tag, ":data"}, 32'(link.data), m_pres ? 32'(exp_q[0]) : 32'd0);
    check_eq({tag, ":count"}, 32'(count), 32'(exp_q.size()));
    check_eq({tag, ":full"}, 32'(in_full), 32'(exp_q.size() == DEPTH));
    check_eq({tag, ":tmo"}, 32'(timeout_err), 32'(m_to));
    check_eq({tag, ":proto"}, 32'(proto_err), 32'(m_pe));
    check_eq({tag, ":ovf"}, 32'(ovf_err), 32'(m_ovf));
    check_eq({tag, ":state"}, 32'(state == VR_PRESENT), 32'(m_pres));
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input string tag, input bit r, input bit wr,
                       input logic [DW-1:0] d, input bit rdy);
    rst = r; in_wr = wr; in_data = d; link.ready = rdy;
    @(posedge clk);
    model_edge(r, wr, d, rdy);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag, 0, 0, '0, 0);
  endtask

  initial begin
    link.ready = 1'b0;
    @(posedge clk); #1;

    // reset state
    cycle("rst", 1, 0, '0, 0);
    cycle("rst", 1, 0, '0, 0);

    // 1: ready two cycles after valid rises
    cycle("t1", 0, 1, 8'hA5, 0);
    check_eq("t1_lat_lo", 32'(link.valid), 32'd0);
    idle("t1", 1);
    check_eq("t1_rise", 32'(link.valid), 32'd1);
    check_eq("t1_data", 32'(link.data), 32'hA5);
    idle("t1", 2);
    cycle("t1", 0, 0, '0, 1);
    check_eq("t1_fell", 32'(link.valid), 32'd0);
    idle("t1", 2);

    // 2: ready on the first valid cycle
    cycle("t2", 0, 1, 8'h11, 0);
    idle("t2", 1);
    check_eq("t2_data", 32'(link.data), 32'h11);
    cycle("t2", 0, 0, '0, 1);
    check_eq("t2_fell", 32'(link.valid), 32'd0);
    idle("t2", 1);

    // 3: four words, immediate ready each time
    for (int i = 1; i <= 4; i++) cycle("t3", 0, 1, DW'(i), link.valid);
    for (int i = 0; i < 10; i++) cycle("t3", 0, 0, '0, link.valid);
    check_eq("t3_empty", 32'(count), 32'd0);

    // 4: overflow with ready withheld
    cycle("t4", 1, 0, '0, 0);
    for (int i = 0; i < 5; i++) cycle("t4", 0, 1, DW'(8'h40 + i), 0);
    check_eq("t4_ovf", 32'(ovf_err), 32'd1);
    check_eq("t4_count", 32'(count), 32'(DEPTH));

    // 5: timeout, then late accept
    cycle("t5", 1, 0, '0, 0);
    cycle("t5", 0, 1, 8'h5C, 0);
    idle("t5", TIMEOUT);
    check_eq("t5_tmo_lo", 32'(timeout_err), 32'd0);
    idle("t5", 1);
    check_eq("t5_tmo", 32'(timeout_err), 32'd1);
    check_eq("t5_hold", 32'(link.valid), 32'd1);
    idle("t5", 3);
    cycle("t5", 0, 0, '0, 1);
    idle("t5", 1);

    // 6: ready in IDLE, then reset mid-PRESENT
    cycle("t6", 1, 0, '0, 0);
    cycle("t6", 0, 0, '0, 1);
    check_eq("t6_proto", 32'(proto_err), 32'd1);
    cycle("t6", 0, 1, 8'h66, 0);
    cycle("t6", 0, 1, 8'h67, 0);
    cycle("t6", 1, 0, '0, 0);
    check_eq("t6_rst_valid", 32'(link.valid), 32'd0);
    check_eq("t6_rst_count", 32'(count), 32'd0);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      bit r, wr, rdy;
      r   = ($urandom_range(0, 199) == 0);
      wr  = ($urandom_range(0, 1) == 1);
      rdy = link.valid ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 99) == 0);
      cycle("rnd", r, wr, DW'($urandom), rdy);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
